// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD word writer.
// LCD_NIBBLE_MODE_EN adds the second-nibble state for the 4-bit bus.
package lcd_pkg;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;

  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_PULSE_CYC = 12;
  localparam int DEF_HOLD_CYC  = 2;
  localparam int DEF_GAP_CYC   = 50;

`ifdef LCD_NIBBLE_MODE_EN
  typedef enum logic [2:0] {
    IDLE, SEL, SETUP, PULSE, HOLD, GAP, NIB2
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, SEL, SETUP, PULSE, HOLD, GAP
  } state_e;
`endif

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Width that holds every value from 0 up to max_len.
  function automatic int cnt_width(input int max_len);
    if (max_len < 1) return 1;
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/lcd_word_writer_timer.sv
// Loadable down-counter timing each bus phase; zero marks the last cycle of a phase.
module lcd_phase_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at zero so an idle timer never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_word_writer.sv
// Walks decoder_4 byte lanes 0..3 and writes each byte to an HD44780-style bus.
// Define LCD_NIBBLE_MODE_EN for the 4-bit interface (two strobes per byte).
module lcd_word_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rs_in,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dec_sel,
  output logic              dec_en,
  input  logic [BYTE_W-1:0] dec_byte,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_e,
  output logic [BYTE_W-1:0] lcd_db
);

  localparam int CNT_W = cnt_width(max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, GAP_CYC));
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [1:0]       LAST_LANE = 2'(LANES - 1);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         dec_sel_q, dec_sel_d;
  logic               dec_en_q, dec_en_d;
  logic               rs_cap_q, rs_cap_d;
  logic               lcd_rs_q, lcd_rs_d;
  logic               lcd_e_q, lcd_e_d;
  logic [BYTE_W-1:0]  lcd_db_q, lcd_db_d;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_zero;

`ifdef LCD_NIBBLE_MODE_EN
  logic               second_q, second_d;
  logic [3:0]         lo_nib_q, lo_nib_d;
`endif

  lcd_phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Each phase reloads the timer with (length - 1) so it ends on the zero cycle.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dec_sel_d = dec_sel_q;
    dec_en_d  = dec_en_q;
    rs_cap_d  = rs_cap_q;
    lcd_rs_d  = lcd_rs_q;
    lcd_db_d  = lcd_db_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
`ifdef LCD_NIBBLE_MODE_EN
    second_d  = second_q;
    lo_nib_d  = lo_nib_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          rs_cap_d  = rs_in;
          dec_sel_d = 2'd0;
          dec_en_d  = 1'b1;
          busy_d    = 1'b1;
          state_d   = SEL;
        end
      end

      SEL: begin
        lcd_rs_d = rs_cap_q;
`ifdef LCD_NIBBLE_MODE_EN
        lcd_db_d = {dec_byte[7:4], 4'b0000};
        lo_nib_d = dec_byte[3:0];
        second_d = 1'b0;
`else
        lcd_db_d = dec_byte;
`endif
        tmr_load = 1'b1;
        tmr_val  = SETUP_LD;
        state_d  = SETUP;
      end

      SETUP: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
          state_d  = PULSE;
        end
      end

      PULSE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
          state_d  = HOLD;
        end
      end

      HOLD: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
`ifdef LCD_NIBBLE_MODE_EN
          if (!second_q) begin
            // Low nibble goes straight into its own setup window, no gap.
            lcd_db_d = {lo_nib_q, 4'b0000};
            second_d = 1'b1;
            tmr_val  = SETUP_LD;
            state_d  = NIB2;
          end else begin
            tmr_val  = GAP_LD;
            state_d  = GAP;
          end
`else
          tmr_val  = GAP_LD;
          state_d  = GAP;
`endif
        end
      end

`ifdef LCD_NIBBLE_MODE_EN
      NIB2: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
          state_d  = PULSE;
        end
      end
`endif

      GAP: begin
        if (tmr_zero) begin
          if (dec_sel_q != LAST_LANE) begin
            dec_sel_d = dec_sel_q + 2'd1;
            state_d   = SEL;
          end else begin
            dec_en_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    lcd_e_d = (state_d == PULSE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dec_sel_q <= 2'd0;
      dec_en_q  <= 1'b0;
      rs_cap_q  <= 1'b0;
      lcd_rs_q  <= 1'b0;
      lcd_e_q   <= 1'b0;
      lcd_db_q  <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dec_sel_q <= dec_sel_d;
      dec_en_q  <= dec_en_d;
      rs_cap_q  <= rs_cap_d;
      lcd_rs_q  <= lcd_rs_d;
      lcd_e_q   <= lcd_e_d;
      lcd_db_q  <= lcd_db_d;
    end
  end

`ifdef LCD_NIBBLE_MODE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      second_q <= 1'b0;
      lo_nib_q <= 4'h0;
    end else begin
      second_q <= second_d;
      lo_nib_q <= lo_nib_d;
    end
  end
`endif

  assign busy    = busy_q;
  assign done    = done_q;
  assign dec_sel = dec_sel_q;
  assign dec_en  = dec_en_q;
  assign lcd_rs  = lcd_rs_q;
  assign lcd_rw  = 1'b0;
  assign lcd_e   = lcd_e_q;
  assign lcd_db  = lcd_db_q;

endmodule

// File: tb/tb_lcd_word_writer.sv
// Scoreboard bench for lcd_word_writer: expected strobes and done cycles are queued
// at start time and matched by a negedge monitor. Honours LCD_NIBBLE_MODE_EN.
module tb_lcd_word_writer;

  localparam int SETUP = 2;
  localparam int PULSE = 12;
  localparam int HOLD  = 2;
  localparam int GAP   = 50;
`ifdef LCD_NIBBLE_MODE_EN
  localparam bit NIB = 1'b1;
  localparam int B   = 1 + 2 * (SETUP + PULSE + HOLD) + GAP;
`else
  localparam bit NIB = 1'b0;
  localparam int B   = 1 + SETUP + PULSE + HOLD + GAP;
`endif

  typedef struct {
    logic [7:0] db;
    logic       rs;
    logic [1:0] lane;
  } strobe_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        rs_in;
  logic        busy;
  logic        done;
  logic [1:0]  dec_sel;
  logic        dec_en;
  logic [7:0]  dec_byte;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_e;
  logic [7:0]  lcd_db;
  logic [31:0] word_r;

  strobe_t exp_q[$];
  int      done_q[$];
  int      total;
  int      bad;
  int      cyc;

  lcd_word_writer #(
    .SETUP_CYC (SETUP),
    .PULSE_CYC (PULSE),
    .HOLD_CYC  (HOLD),
    .GAP_CYC   (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rs_in    (rs_in),
    .busy     (busy),
    .done     (done),
    .dec_sel  (dec_sel),
    .dec_en   (dec_en),
    .dec_byte (dec_byte),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_db   (lcd_db)
  );

  // Stand-in for decoder_4: combinational lane select out of the word under test.
  assign dec_byte = dec_en ? word_r[{dec_sel, 3'b000} +: 8] : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Caller is positioned at a negedge; start is seen by the DUT on the next posedge.
  task automatic applyStimulus(input logic [31:0] w, input logic rs);
    strobe_t s;
    word_r = w;
    rs_in  = rs;
    start  = 1'b1;
    for (int l = 0; l < 4; l++) begin
      s.rs   = rs;
      s.lane = 2'(l);
      if (NIB) begin
        s.db = {w[l*8+4 +: 4], 4'h0};
        exp_q.push_back(s);
        s.db = {w[l*8 +: 4], 4'h0};
        exp_q.push_back(s);
      end else begin
        s.db = w[l*8 +: 8];
        exp_q.push_back(s);
      end
    end
    done_q.push_back(cyc + 1 + 4 * B);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitLane(input logic [1:0] lane, input bit need_e, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy && dec_sel == lane && (!need_e || lcd_e)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Monitor: matches each lcd_e rise and each done pulse against the queues.
  initial begin
    logic       prev_e;
    logic [7:0] prev_db;
    int         rise_cyc, fall_cyc, change_cyc, pulse_idx, busy_run, exp_low, exp_done;
    bit         fall_seen, db_changed;
    strobe_t    s;
    prev_e = 1'b0; prev_db = 8'h00; rise_cyc = 0; fall_cyc = 0; change_cyc = 0;
    pulse_idx = 0; busy_run = 0; fall_seen = 1'b0; db_changed = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pulse_idx  = 0;
        busy_run   = 0;
        fall_seen  = 1'b0;
        db_changed = 1'b0;
      end else begin
        if (done) begin
          if (done_q.size() == 0) begin
            checkOutput("done_unexpected", done_q.size(), 1);
          end else begin
            exp_done = done_q.pop_front();
            checkOutput("done_cycle", cyc, exp_done);
          end
          checkOutput("busy_at_done", busy, 0);
          checkOutput("busy_len", busy_run, 4 * B);
          pulse_idx = 0;
          fall_seen = 1'b0;
        end
        if (lcd_db != prev_db) begin
          if (fall_seen) checkOutput("db_hold_min", (cyc - fall_cyc >= HOLD) ? 1 : 0, 1);
          checkOutput("db_change_e_low", lcd_e, 0);
          change_cyc = cyc;
          db_changed = 1'b1;
        end
        if (lcd_e && !prev_e) begin
          if (exp_q.size() == 0) begin
            checkOutput("strobe_unexpected", exp_q.size(), 1);
          end else begin
            s = exp_q.pop_front();
            checkOutput("strobe_db", lcd_db, s.db);
            checkOutput("strobe_rs", lcd_rs, s.rs);
            checkOutput("strobe_lane", dec_sel, s.lane);
            checkOutput("strobe_dec_en", dec_en, 1);
            checkOutput("strobe_rw", lcd_rw, 0);
          end
          if (db_changed) checkOutput("setup_cycles", cyc - change_cyc, SETUP);
          if (pulse_idx > 0) begin
            exp_low = (NIB && (pulse_idx % 2 == 1)) ? (HOLD + SETUP) : (HOLD + GAP + 1 + SETUP);
            checkOutput("low_run", cyc - fall_cyc, exp_low);
          end
          db_changed = 1'b0;
          rise_cyc   = cyc;
          pulse_idx++;
        end
        if (!lcd_e && prev_e) begin
          checkOutput("pulse_width", cyc - rise_cyc, PULSE);
          fall_cyc  = cyc;
          fall_seen = 1'b1;
        end
        busy_run = busy ? busy_run + 1 : 0;
      end
      prev_e  = lcd_e;
      prev_db = lcd_db;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    total  = 0;
    bad    = 0;
    rst    = 1'b0;
    start  = 1'b0;
    rs_in  = 1'b0;
    word_r = 32'h0;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_dec_sel", dec_sel, 0);
    checkOutput("rst_dec_en", dec_en, 0);
    checkOutput("rst_lcd_rs", lcd_rs, 0);
    checkOutput("rst_lcd_rw", lcd_rw, 0);
    checkOutput("rst_lcd_e", lcd_e, 0);
    checkOutput("rst_lcd_db", lcd_db, 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_lcd_e", lcd_e, 0);

    $display("[TB] word A1B2C3D4 rs=1");
    applyStimulus(32'hA1B2C3D4, 1'b1);
    checkOutput("busy_after_start", busy, 1);
    waitDone(8 * B, ok);
    checkOutput("wait_done_1", ok, 1);

    $display("[TB] ignored start during lane 2, restart in done cycle");
    repeat (5) @(negedge clk);
    applyStimulus(32'h11223344, 1'b0);
    waitLane(2'd2, 1'b0, 4 * B, ok);
    checkOutput("wait_lane2", ok, 1);
    start = 1'b1;
    rs_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(8 * B, ok);
    checkOutput("wait_done_2", ok, 1);
    applyStimulus(32'h55667788, 1'b1);
    checkOutput("busy_restart", busy, 1);
    waitDone(8 * B, ok);
    checkOutput("wait_done_3", ok, 1);

    $display("[TB] reset while lcd_e high in lane 1");
    repeat (5) @(negedge clk);
    applyStimulus(32'hCAFEF00D, 1'b1);
    waitLane(2'd1, 1'b1, 4 * B, ok);
    checkOutput("wait_lane1_e", ok, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_lcd_e", lcd_e, 0);
    checkOutput("async_busy", busy, 0);
    checkOutput("async_dec_en", dec_en, 0);
    exp_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("post_rst_idle", busy, 0);
    applyStimulus(32'h0F1E2D3C, 1'b0);
    waitDone(8 * B, ok);
    checkOutput("wait_done_4", ok, 1);

    $display("[TB] word 0000005A rs=0");
    repeat (3) @(negedge clk);
    applyStimulus(32'h0000005A, 1'b0);
    waitDone(8 * B, ok);
    checkOutput("wait_done_5", ok, 1);

    repeat (10) @(negedge clk);
    checkOutput("exp_q_drained", exp_q.size(), 0);
    checkOutput("done_q_drained", done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
